// File: rtl/reg_file_ctrl.sv
// Arbiter/sequencer sharing the register file write port and X address between CPU, debug port and a clear sequence.
// Define RF_CLR_ON_RESET_EN to start a full clear sequence straight out of reset.
module reg_file_ctrl #(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 5,
    parameter logic [DATA_W-1:0] CLR_VALUE    = '0,
    parameter int                STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] cpu_adrx_i,
    input  logic [ADDR_W-1:0] cpu_adry_i,
    input  logic [DATA_W-1:0] cpu_din_i,
    input  logic              cpu_wr_i,
    output logic              stall_o,
    input  logic              clr_req_i,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_adr_i,
    input  logic [DATA_W-1:0] dbg_din_i,
    output logic              dbg_gnt_o,
    output logic [DATA_W-1:0] dbg_dout_o,
    output logic              dbg_valid_o,
    output logic [ADDR_W-1:0] rf_adrx_o,
    output logic [ADDR_W-1:0] rf_adry_o,
    output logic [DATA_W-1:0] rf_din_o,
    output logic              rf_wr_o,
    input  logic [DATA_W-1:0] rf_dx_i
);

    localparam int              NREGS      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST   = (ADDR_W + 1)'(NREGS - 1);
    localparam logic [ADDR_W:0] CLR_STEP   = (ADDR_W + 1)'(1);
    localparam logic [7:0]      WAIT_LIMIT = 8'(STARVE_LIMIT);
    localparam logic [7:0]      WAIT_MAX   = 8'hFF;
    localparam logic [7:0]      WAIT_STEP  = 8'h01;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DBG   = 2'd2
    } state_e;

`ifdef RF_CLR_ON_RESET_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_RUN;
`endif

    state_e            state_q;
    logic [ADDR_W:0]   clr_cnt_q;
    logic [7:0]        wait_cnt_q;
    logic [DATA_W-1:0] dbg_dout_q;
    logic              dbg_valid_q;
    logic              dbg_win;

    // The valid term forces one RUN cycle between debug accesses so a held request cannot hog the file.
    assign dbg_win = dbg_req_i && (!cpu_wr_i || (wait_cnt_q >= WAIT_LIMIT)) && !dbg_valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            dbg_dout_q  <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            dbg_valid_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + CLR_STEP;
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clr_req_i) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                    end else if (dbg_win) begin
                        state_q <= ST_DBG;
                    end

                    if (!clr_req_i && dbg_win) begin
                        wait_cnt_q <= '0;
                    end else if (!dbg_req_i) begin
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_q <= wait_cnt_q + WAIT_STEP;
                    end
                end
                ST_DBG: begin
                    dbg_dout_q  <= rf_dx_i;
                    dbg_valid_q <= 1'b1;
                    state_q     <= ST_RUN;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Whoever owns the file this cycle steers the shared X address and write port.
    always_comb begin
        rf_adrx_o = cpu_adrx_i;
        rf_din_o  = cpu_din_i;
        rf_wr_o   = 1'b0;
        case (state_q)
            ST_RUN: begin
                rf_wr_o = cpu_wr_i;
            end
            ST_CLEAR: begin
                rf_adrx_o = clr_cnt_q[ADDR_W-1:0];
                rf_din_o  = CLR_VALUE;
                rf_wr_o   = 1'b1;
            end
            ST_DBG: begin
                rf_adrx_o = dbg_adr_i;
                rf_din_o  = dbg_din_i;
                rf_wr_o   = dbg_we_i;
            end
            default: begin
                rf_wr_o = 1'b0;
            end
        endcase
    end

    assign rf_adry_o   = cpu_adry_i;
    assign stall_o     = (state_q != ST_RUN);
    assign dbg_gnt_o   = (state_q == ST_DBG);
    assign dbg_dout_o  = dbg_dout_q;
    assign dbg_valid_o = dbg_valid_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: behavioural 32x8 register file, table-driven CPU vectors and a debug-read scoreboard.
// Expectations follow RF_CLR_ON_RESET_EN when it is defined for the build.
module tb_reg_file_ctrl;

    localparam int         NREGS   = 32;
    localparam int         STARVE  = 8;
    localparam logic [7:0] CLR_VAL = 8'h00;

    logic       clk = 1'b0;
    logic       rstN;
    logic [4:0] cpuAdrx, cpuAdry, dbgAdr, rfAdrx, rfAdry;
    logic [7:0] cpuDin, dbgDin, dbgDout, rfDin, rfDx;
    logic       cpuWr, stall, clrReq, dbgReq, dbgWe, dbgGnt, dbgValid, rfWr;

    logic [7:0] rfMem [NREGS] = '{default: 8'hEE};
    logic [7:0] expMem [NREGS];
    logic [7:0] sbQueue [$];
    int         total = 0;
    int         bad = 0;

    typedef struct {
        logic       wr;
        logic [4:0] adrx;
        logic [4:0] adry;
        logic [7:0] din;
        logic       expStall;
        logic       expWr;
        logic [4:0] expAdrx;
        logic [4:0] expAdry;
        logic [7:0] expDin;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    // Register file model: synchronous write, asynchronous X read.
    always @(posedge clk) begin
        if (rfWr) rfMem[rfAdrx] <= rfDin;
    end
    assign rfDx = rfMem[rfAdrx];

    reg_file_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .cpu_adrx_i  (cpuAdrx),
        .cpu_adry_i  (cpuAdry),
        .cpu_din_i   (cpuDin),
        .cpu_wr_i    (cpuWr),
        .stall_o     (stall),
        .clr_req_i   (clrReq),
        .dbg_req_i   (dbgReq),
        .dbg_we_i    (dbgWe),
        .dbg_adr_i   (dbgAdr),
        .dbg_din_i   (dbgDin),
        .dbg_gnt_o   (dbgGnt),
        .dbg_dout_o  (dbgDout),
        .dbg_valid_o (dbgValid),
        .rf_adrx_o   (rfAdrx),
        .rf_adry_o   (rfAdry),
        .rf_din_o    (rfDin),
        .rf_wr_o     (rfWr),
        .rf_dx_i     (rfDx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkPop(input string name);
        logic [7:0] e;
        if (sbQueue.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: got dout 0x%0h, want scoreboard entry (queue empty)", name, dbgDout);
        end else begin
            e = sbQueue.pop_front();
            checkOutput(name, 32'(dbgDout), 32'(e));
        end
    endtask

    task automatic checkClearSeq(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            checkOutput({tag, " clear cycle"}, 32'({stall, rfWr, rfAdrx, dbgGnt}),
                        32'({1'b1, 1'b1, 5'(i), 1'b0}));
            step();
        end
        checkOutput({tag, " stall after clear"}, 32'(stall), 32'd0);
        for (int i = 0; i < NREGS; i++) expMem[i] = CLR_VAL;
    endtask

    task automatic applyStimulus(input vec_t v);
        cpuWr   = v.wr;
        cpuAdrx = v.adrx;
        cpuAdry = v.adry;
        cpuDin  = v.din;
        #1;
        checkOutput("table rf path", 32'({stall, rfWr, rfAdrx, rfAdry, rfDin}),
                    32'({v.expStall, v.expWr, v.expAdrx, v.expAdry, v.expDin}));
        if (v.wr) expMem[v.adrx] = v.din;
        step();
    endtask

    task automatic dbgAccess(input logic we, input logic [4:0] adr, input logic [7:0] din, input int expWait);
        int n;
        n      = 0;
        dbgReq = 1'b1;
        dbgWe  = we;
        dbgAdr = adr;
        dbgDin = din;
        sbQueue.push_back(expMem[adr]);
        do begin
            step();
            n++;
        end while (!dbgGnt && n < 100);
        if (!dbgGnt) begin
            checkOutput("dbg grant timeout", 32'(dbgGnt), 32'd1);
            void'(sbQueue.pop_back());
            dbgReq = 1'b0;
        end else begin
            if (expWait >= 0) checkOutput("dbg grant latency", 32'(n), 32'(expWait));
            checkOutput("dbg grant mux", 32'({stall, rfWr, rfAdrx, rfDin}), 32'({1'b1, we, adr, din}));
            if (we) expMem[adr] = din;
            step();
            checkOutput("dbg valid", 32'(dbgValid), 32'd1);
            checkPop("dbg dout");
            dbgReq = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int validCnt;
        int n;

        vecs[0] = '{1'b1, 5'd5,  5'd2,  8'hA5, 1'b0, 1'b1, 5'd5,  5'd2,  8'hA5};
        vecs[1] = '{1'b0, 5'd6,  5'd31, 8'hFF, 1'b0, 1'b0, 5'd6,  5'd31, 8'hFF};
        vecs[2] = '{1'b1, 5'd12, 5'd0,  8'h5A, 1'b0, 1'b1, 5'd12, 5'd0,  8'h5A};
        vecs[3] = '{1'b1, 5'd20, 5'd7,  8'hC3, 1'b0, 1'b1, 5'd20, 5'd7,  8'hC3};
        vecs[4] = '{1'b1, 5'd31, 5'd31, 8'h81, 1'b0, 1'b1, 5'd31, 5'd31, 8'h81};
        vecs[5] = '{1'b0, 5'd0,  5'd1,  8'h00, 1'b0, 1'b0, 5'd0,  5'd1,  8'h00};

        for (int i = 0; i < NREGS; i++) expMem[i] = 8'hEE;
        rstN = 1'b0; cpuAdrx = '0; cpuAdry = '0; cpuDin = '0; cpuWr = 1'b0;
        clrReq = 1'b0; dbgReq = 1'b0; dbgWe = 1'b0; dbgAdr = '0; dbgDin = '0;

        step();
        step();
        checkOutput("reset valid", 32'(dbgValid), 32'd0);
        checkOutput("reset dout", 32'(dbgDout), 32'd0);
        checkOutput("reset gnt", 32'(dbgGnt), 32'd0);
`ifdef RF_CLR_ON_RESET_EN
        checkOutput("reset stall", 32'(stall), 32'd1);
        checkOutput("reset clear addr", 32'(rfAdrx), 32'd0);
        rstN = 1'b1;
        checkClearSeq("power-on");
`else
        checkOutput("reset stall", 32'(stall), 32'd0);
        rstN = 1'b1;
        step();
`endif

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);
        cpuWr = 1'b0;
        step();
        step();

        dbgAccess(1'b0, 5'd5, 8'h00, 1);

        step();
        cpuWr = 1'b1; cpuAdrx = 5'd7; cpuDin = 8'h77;
        expMem[7] = 8'h77;
        dbgAccess(1'b1, 5'd3, 8'h3C, STARVE + 1);
        cpuWr = 1'b0;
        step();
        dbgAccess(1'b0, 5'd3, 8'h00, -1);
        dbgAccess(1'b0, 5'd7, 8'h00, -1);

        // Held request: grant, valid, one forced RUN cycle, then grant again.
        step();
        step();
        dbgReq = 1'b1; dbgWe = 1'b0; dbgAdr = 5'd5;
        validCnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checkOutput("b2b gnt pattern", 32'(dbgGnt), 32'((k % 3) == 1));
            if (dbgValid) begin
                validCnt++;
                checkOutput("b2b dout", 32'(dbgDout), 32'(expMem[5]));
            end
        end
        dbgReq = 1'b0;
        checkOutput("b2b valid count", 32'(validCnt), 32'd4);

        dbgAccess(1'b0, 5'd12, 8'h00, -1);
        step();
        clrReq = 1'b1;
        step();
        clrReq = 1'b0;
        checkOutput("clear start addr", 32'(rfAdrx), 32'd0);
        repeat (10) step();
        checkOutput("clear mid addr", 32'({stall, rfAdrx}), 32'({1'b1, 5'd10}));
        rstN = 1'b0;
        step();
        for (int i = 0; i <= 10; i++) expMem[i] = CLR_VAL;
        checkOutput("rst mid clear valid", 32'(dbgValid), 32'd0);
        checkOutput("rst mid clear dout", 32'(dbgDout), 32'd0);
`ifdef RF_CLR_ON_RESET_EN
        checkOutput("rst mid clear restart", 32'({stall, rfAdrx}), 32'({1'b1, 5'd0}));
        rstN = 1'b1;
        checkClearSeq("restart");
`else
        checkOutput("rst mid clear stall", 32'(stall), 32'd0);
        rstN = 1'b1;
        step();
`endif

        cpuWr = 1'b1; cpuAdrx = 5'd20; cpuDin = 8'hC3;
        expMem[20] = 8'hC3;
        step();
        cpuWr = 1'b0;
        dbgAccess(1'b0, 5'd20, 8'h00, -1);
        step();
        dbgReq = 1'b1; dbgWe = 1'b0; dbgAdr = 5'd20;
        n = 0;
        do begin
            step();
            n++;
        end while (!dbgGnt && n < 50);
        checkOutput("mid dbg grant", 32'(dbgGnt), 32'd1);
        rstN = 1'b0;
        dbgReq = 1'b0;
        step();
        checkOutput("rst mid dbg valid", 32'(dbgValid), 32'd0);
        checkOutput("rst mid dbg dout", 32'(dbgDout), 32'd0);
`ifdef RF_CLR_ON_RESET_EN
        rstN = 1'b1;
        checkClearSeq("dbg abort");
`else
        checkOutput("rst mid dbg stall", 32'(stall), 32'd0);
        rstN = 1'b1;
        step();
        checkOutput("rst mid dbg no late valid", 32'(dbgValid), 32'd0);
`endif

        // Clear request and debug request together: clear must run first.
        step();
        clrReq = 1'b1; dbgReq = 1'b1; dbgWe = 1'b0; dbgAdr = 5'd9;
        step();
        clrReq = 1'b0;
        checkOutput("clear beats dbg", 32'({stall, dbgGnt}), 32'({1'b1, 1'b0}));
        checkClearSeq("clr+dbg");
        sbQueue.push_back(expMem[9]);
        step();
        checkOutput("dbg after clear gnt", 32'(dbgGnt), 32'd1);
        step();
        checkOutput("dbg after clear valid", 32'(dbgValid), 32'd1);
        checkPop("dbg after clear dout");
        dbgReq = 1'b0;
        step();

        for (int i = 0; i < NREGS; i++) dbgAccess(1'b0, 5'(i), 8'h00, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
